// File: rtl/button_ctrl_pkg.sv
// Shared definitions for the front-panel button input block.
// Holds the auto-repeat FSM state type, the default channel masks for the
// five-button stopwatch panel, the channel index constants and a small
// constant helper used when sizing the repeat counter.
package button_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    localparam int N_BUTTONS_DEF = 5;

    // Bit order: up, centre, down, left, right.
    localparam int BTN_UP     = 0;
    localparam int BTN_CENTRE = 1;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 3;
    localparam int BTN_RIGHT  = 4;

    // Auto-repeat on up, down and right; toggle latch on centre ("set" mode).
    localparam logic [N_BUTTONS_DEF-1:0] REPEAT_MASK_DEF = 5'b10101;
    localparam logic [N_BUTTONS_DEF-1:0] TOGGLE_MASK_DEF = 5'b00010;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// Single button channel: two-flop synchroniser, debouncer, press-pulse
// generation, optional auto-repeat FSM and optional toggle latch.
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   btn_i          raw asynchronous button level (active-high)
//   enable_i       when low, press pulses, repeats and toggles are dropped
//   toggle_clear_i synchronous clear of the toggle latch (wins over a press)
//   pulse_o        one-cycle press / repeat pulse (registered)
//   held_o         debounced level (registered)
//   toggle_o       toggle latch state (0 when TOGGLE_EN is 0)
module button_channel
    import button_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 20,
    parameter int REPEAT_PERIOD   = 8,
    parameter bit REPEAT_EN       = 1'b0,
    parameter bit TOGGLE_EN       = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    input  logic enable_i,
    input  logic toggle_clear_i,
    output logic pulse_o,
    output logic held_o,
    output logic toggle_o
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = max2(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    // The flip happens on the sample that would take the count to DEBOUNCE_CYCLES.
    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);
    localparam logic [RPT_W-1:0] RPT_DLY_C  = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_PER_C  = RPT_W'(REPEAT_PERIOD);

    logic             s1_q, s2_q;
    logic             held_q, held_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    rpt_state_e       state_q, state_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             pulse_q, pulse_d;
    logic             toggle_q, toggle_d;
    logic             press;
    logic             rpt_fire;

    function automatic logic [RPT_W-1:0] sat_inc(input logic [RPT_W-1:0] v);
        return (v == {RPT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            held_q    <= 1'b0;
            db_cnt_q  <= '0;
            state_q   <= IDLE;
            rpt_cnt_q <= '0;
            pulse_q   <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            s1_q      <= btn_i;
            s2_q      <= s1_q;
            held_q    <= held_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
            pulse_q   <= pulse_d;
            toggle_q  <= toggle_d;
        end
    end

    // Debouncer: any agreeing sample restarts the run of disagreeing ones.
    always_comb begin
        db_cnt_d = '0;
        held_d   = held_q;
        if (s2_q != held_q) begin
            if (db_cnt_q == DB_LAST) begin
                held_d = ~held_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Press is qualified with the next held value so the pulse register
    // rises on the same edge as held_q.
    assign press = held_d & ~held_q & enable_i;

    // Repeat FSM. Looking at held_d means a repeat falling due on the release
    // edge is dropped together with the held level.
    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        rpt_fire  = 1'b0;
        if (!REPEAT_EN || !held_d || !enable_i) begin
            state_d   = IDLE;
            rpt_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press) begin
                        state_d   = DELAY;
                        rpt_cnt_d = RPT_ONE;
                    end
                end
                DELAY: begin
                    if (rpt_cnt_q == RPT_DLY_C) begin
                        rpt_fire  = 1'b1;
                        state_d   = REPEAT;
                        rpt_cnt_d = RPT_ONE;
                    end else begin
                        rpt_cnt_d = sat_inc(rpt_cnt_q);
                    end
                end
                REPEAT: begin
                    if (rpt_cnt_q == RPT_PER_C) begin
                        rpt_fire  = 1'b1;
                        rpt_cnt_d = RPT_ONE;
                    end else begin
                        rpt_cnt_d = sat_inc(rpt_cnt_q);
                    end
                end
                default: begin
                    state_d   = IDLE;
                    rpt_cnt_d = '0;
                end
            endcase
        end
    end

    assign pulse_d = press | rpt_fire;

    // Only the press pulse flips the latch; repeats never do.
    always_comb begin
        toggle_d = toggle_q;
        if (!TOGGLE_EN || toggle_clear_i) begin
            toggle_d = 1'b0;
        end else if (press) begin
            toggle_d = ~toggle_q;
        end
    end

    assign pulse_o  = pulse_q;
    assign held_o   = held_q;
    assign toggle_o = toggle_q;

endmodule

// File: rtl/button_input_controller.sv
// N-channel front-panel input block for the stopwatch. Each channel is a
// button_channel instance; this level fans out enable and toggle_clear and
// selects auto-repeat / toggle behaviour per channel from the masks.
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   buttons_in   raw button levels (bit order up, centre, down, left, right)
//   enable       when low, suppresses pulses, repeats and toggles
//   toggle_clear synchronous clear of all toggle latches
//   pulse_out    one-cycle press and repeat pulses
//   held_out     debounced button levels
//   toggle_out   toggle latch states (0 outside TOGGLE_MASK)
module button_input_controller
    import button_ctrl_pkg::*;
#(
    parameter int                    N_BUTTONS       = N_BUTTONS_DEF,
    parameter int                    DEBOUNCE_CYCLES = 4,
    parameter int                    REPEAT_DELAY    = 20,
    parameter int                    REPEAT_PERIOD   = 8,
    parameter logic [N_BUTTONS-1:0]  REPEAT_MASK     = N_BUTTONS'(REPEAT_MASK_DEF),
    parameter logic [N_BUTTONS-1:0]  TOGGLE_MASK     = N_BUTTONS'(TOGGLE_MASK_DEF)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] buttons_in,
    input  logic                 enable,
    input  logic                 toggle_clear,
    output logic [N_BUTTONS-1:0] pulse_out,
    output logic [N_BUTTONS-1:0] held_out,
    output logic [N_BUTTONS-1:0] toggle_out
);

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_MASK[i]),
            .TOGGLE_EN       (TOGGLE_MASK[i])
        ) u_ch (
            .clk_i          (clk),
            .rst_ni         (rst),
            .btn_i          (buttons_in[i]),
            .enable_i       (enable),
            .toggle_clear_i (toggle_clear),
            .pulse_o        (pulse_out[i]),
            .held_o         (held_out[i]),
            .toggle_o       (toggle_out[i])
        );
    end

endmodule
